// File: rtl/ca_readout.sv
//==============================================================================
// Module   : ca_readout
// Purpose  : Buffers captured 32-bit CA rows in a DEPTH-entry FIFO and
//            serializes each row LSB-first as bytes over a valid/ready link.
//            Define CA_READOUT_GEN_TAG_EN to prefix every row with an 8-bit
//            generation tag byte.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ca_readout #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] row,
    input  logic        row_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overflow,
    output logic        busy
);

    localparam int c_AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

`ifdef CA_READOUT_GEN_TAG_EN
    localparam int c_EW     = 40;
    localparam int c_NBYTES = 5;
`else
    localparam int c_EW     = 32;
    localparam int c_NBYTES = 4;
`endif

    localparam logic [2:0] c_LAST_IDX = 3'(c_NBYTES - 1);
    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_SEND     = 1'b1;
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_EW-1:0] r_shift;
    logic [2:0]      r_byte_idx;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_advance;
    logic            w_write;
    logic            w_drop;
    logic [c_EW-1:0] w_entry_in;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

`ifdef CA_READOUT_GEN_TAG_EN
    logic [7:0] r_gen;

    // Counts every strobe, dropped rows included, so gaps in tags reveal loss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gen <= 8'd0;
        end else if (row_valid) begin
            r_gen <= r_gen + 8'd1;
        end
    end

    assign w_entry_in = {row, r_gen};
`else
    assign w_entry_in = row;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_advance   = 1'b0;
        if (r_state == c_IDLE) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = c_SEND;
            end
        end else begin
            if (tx_ready) begin
                if (r_byte_idx == c_LAST_IDX) begin
                    // Reload straight from the FIFO so consecutive rows have no gap.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else begin
                    w_advance = 1'b1;
                end
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_write = row_valid && (!w_full || w_pop);
    assign w_drop  = row_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_entry_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_state    <= c_IDLE;
            r_shift    <= '0;
            r_byte_idx <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_shift    <= r_mem[r_rd_ptr[c_AW-1:0]];
                r_byte_idx <= 3'd0;
            end else if (w_advance) begin
                r_shift    <= {8'h00, r_shift[c_EW-1:8]};
                r_byte_idx <= r_byte_idx + 3'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign tx_valid = (r_state == c_SEND);
    assign tx_data  = r_shift[7:0];
    assign overflow = r_overflow;
    assign busy     = !w_empty || (r_state == c_SEND);

endmodule

`default_nettype wire

// File: tb/tb_ca_readout.sv
//==============================================================================
// Module   : tb_ca_readout
// Purpose  : Directed self-checking bench for ca_readout (DEPTH = 4).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ca_readout;

`ifdef CA_READOUT_GEN_TAG_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] row = 32'h0;
    logic        row_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    ca_readout #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .row_valid (row_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input logic [31:0] r, input logic [7:0] tag, input int k);
`ifdef CA_READOUT_GEN_TAG_EN
        if (k == 0) return tag;
        return r[8*(k-1) +: 8];
`else
        return r[8*k +: 8];
`endif
    endfunction

    task automatic push_exp(input logic [31:0] r, input logic [7:0] tag);
        for (int k = 0; k < NB; k++) expq.push_back(exp_byte(r, tag, k));
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1; row_valid = 1'b0; tx_ready = 1'b0; row = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        expq.delete();
    endtask

    // Collects bytes with tx_ready held high, starting at the current negedge.
    task automatic drain(input int n, input int max_cycles, output bit ok);
        int cyc;
        cyc = 0;
        ok  = 1'b1;
        forever begin
            tx_ready = 1'b1;
            if (tx_valid) rxq.push_back(tx_data);
            if (rxq.size() >= n) break;
            cyc++;
            if (cyc > max_cycles) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        // A strobe while reset is held must leave nothing behind.
        row = 32'h1234_5678; row_valid = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; row_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_coincident_busy: got %b expected 0", busy); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_coincident_valid: got %b expected 0", tx_valid); end
    endtask

    task automatic test_basic;
        bit ok;
        apply_reset();
        @(negedge clk);
        row = 32'hA5C3_0F81; row_valid = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        row_valid = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", tx_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b expected 1", tx_valid); end
        push_exp(32'hA5C3_0F81, 8'd0);
        drain(NB, NB - 1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_consecutive: got %0d bytes expected %0d", rxq.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            n_checks++; if (rxq[k] !== expq[k]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", k, rxq[k], expq[k]); end
        end
`ifndef CA_READOUT_GEN_TAG_EN
        n_checks++; if ({rxq[3], rxq[2], rxq[1], rxq[0]} !== 32'hA5C3_0F81) begin n_fail++; $display("FAIL basic_order: got %h%h%h%h expected 810FC3A5", rxq[0], rxq[1], rxq[2], rxq[3]); end
`endif
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid: got %b expected 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    // The first row parks in the shift register while tx_ready is low, so
    // one leading row plus four more fill the FIFO and the sixth is dropped.
    task automatic test_overflow;
        bit ok;
        logic [31:0] rows[6];
        rows = '{32'h1111_0001, 32'h2222_0102, 32'h3333_0203, 32'h4444_0304, 32'h5555_0405, 32'h6666_0506};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before_drop: got %b expected 0", overflow); end
            end
            row = rows[i]; row_valid = 1'b1;
        end
        @(negedge clk);
        row_valid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_stalled_valid: got %b expected 1", tx_valid); end
        for (int i = 0; i < 5; i++) push_exp(rows[i], 8'(i));
        drain(5 * NB, 200, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ovf_timeout: got %0d bytes expected %0d", rxq.size(), 5 * NB); end
        for (int k = 0; k < 5 * NB; k++) begin
            n_checks++; if (rxq[k] !== expq[k]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", k, rxq[k], expq[k]); end
        end
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_extra_row: got %b expected 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_idle_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rows[3];
        logic        prev_valid, prev_ready;
        logic [7:0]  prev_data;
        rows = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            row = rows[i]; row_valid = 1'b1;
            push_exp(rows[i], 8'(i));
        end
        @(negedge clk);
        row_valid  = 1'b0;
        prev_valid = tx_valid;
        prev_ready = tx_ready;
        prev_data  = tx_data;
        for (int c = 0; c < 400 && rxq.size() < 3 * NB; c++) begin
            @(negedge clk);
            if (prev_valid && !prev_ready) begin
                n_checks++; if (tx_valid !== 1'b1 || tx_data !== prev_data) begin n_fail++; $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, prev_data); end
            end
            tx_ready = 1'($urandom_range(0, 1));
            if (tx_valid && tx_ready) rxq.push_back(tx_data);
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
        end
        n_checks++; if (rxq.size() != 3 * NB) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", rxq.size(), 3 * NB); end
        for (int k = 0; k < 3 * NB; k++) begin
            n_checks++; if (rxq[k] !== expq[k]) begin n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", k, rxq[k], expq[k]); end
        end
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_simul;
        bit ok;
        logic [31:0] rows[6];
        rows = '{32'hF0E1_D2C3, 32'h0A0B_0C0D, 32'h1A1B_1C1D, 32'h2A2B_2C2D, 32'h3A3B_3C3D, 32'h7E7F_8081};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            row = rows[i]; row_valid = 1'b1;
        end
        @(negedge clk);
        row_valid = 1'b0; tx_ready = 1'b1;
        n_checks++; if (tx_data !== exp_byte(rows[0], 8'd0, 0)) begin n_fail++; $display("FAIL full_head_byte0: got %h expected %h", tx_data, exp_byte(rows[0], 8'd0, 0)); end
        for (int j = 1; j < NB; j++) begin
            @(negedge clk);
            n_checks++; if (tx_data !== exp_byte(rows[0], 8'd0, j)) begin n_fail++; $display("FAIL full_head_byte%0d: got %h expected %h", j, tx_data, exp_byte(rows[0], 8'd0, j)); end
            if (j == NB - 1) begin
                row = rows[5]; row_valid = 1'b1;
            end
        end
        @(negedge clk);
        row_valid = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_simul_overflow: got %b expected 0", overflow); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_byte(rows[1], 8'd1, 0)) begin n_fail++; $display("FAIL full_no_bubble: got valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, exp_byte(rows[1], 8'd1, 0)); end
        for (int i = 1; i < 6; i++) push_exp(rows[i], 8'(i));
        drain(5 * NB, 5 * NB - 1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_timeout: got %0d bytes expected %0d", rxq.size(), 5 * NB); end
        for (int k = 0; k < 5 * NB; k++) begin
            n_checks++; if (rxq[k] !== expq[k]) begin n_fail++; $display("FAIL full_byte%0d: got %h expected %h", k, rxq[k], expq[k]); end
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_end: got busy=%b overflow=%b expected 0 0", busy, overflow); end
    endtask

    task automatic test_reset_mid_row;
        bit ok;
        apply_reset();
        @(negedge clk);
        row = 32'hCAFE_F00D; row_valid = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        row_valid = 1'b0;
        repeat (3) @(negedge clk);
        // Two bytes have transferred; the third is on the bus.
        n_checks++; if (tx_data !== exp_byte(32'hCAFE_F00D, 8'd0, 2)) begin n_fail++; $display("FAIL midrst_pre: got %h expected %h", tx_data, exp_byte(32'hCAFE_F00D, 8'd0, 2)); end
        rst = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", tx_data); end
        @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        expq.delete();
        @(negedge clk);
        row = 32'h7654_3210; row_valid = 1'b1;
        @(negedge clk);
        row_valid = 1'b0;
        @(negedge clk);
        push_exp(32'h7654_3210, 8'd0);
        drain(NB, NB - 1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_timeout: got %0d bytes expected %0d", rxq.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            n_checks++; if (rxq[k] !== expq[k]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h expected %h", k, rxq[k], expq[k]); end
        end
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_leftover: got %b expected 0", tx_valid); end
    endtask

`ifdef CA_READOUT_GEN_TAG_EN
    task automatic test_gen_tag;
        bit ok;
        logic [31:0] rows[3];
        rows = '{32'h4433_2211, 32'h8877_6655, 32'hCCBB_AA99};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            row = rows[i]; row_valid = 1'b1; tx_ready = 1'b1;
        end
        @(negedge clk);
        row_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expq.push_back(8'(i));
            for (int k = 0; k < 4; k++) expq.push_back(rows[i][8*k +: 8]);
        end
        drain(15, 100, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tag_timeout: got %0d bytes expected 15", rxq.size()); end
        for (int k = 0; k < 15; k++) begin
            n_checks++; if (rxq[k] !== expq[k]) begin n_fail++; $display("FAIL tag_byte%0d: got %h expected %h", k, rxq[k], expq[k]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_full_simul();
        test_reset_mid_row();
`ifdef CA_READOUT_GEN_TAG_EN
        test_gen_tag();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
